// File: rtl/game_turn_ctrl_if.sv
// Shared constants and the move/judger/RAM-write bundle used by game_turn_ctrl.
// The controller connects through the master modport; its environment uses the slave modport.
package game_turn_pkg;
  localparam int unsigned POS_W  = 6;
  localparam int unsigned CNT_W  = 7;
  localparam int unsigned RES_W  = 2;
  localparam int unsigned CELL_W = 2;

  localparam logic SIDE_RED   = 1'b0;
  localparam logic SIDE_GREEN = 1'b1;

  localparam logic [RES_W-1:0] JUDGER_INVALID = 2'd0;
  localparam logic [RES_W-1:0] JUDGER_VALID   = 2'd1;
  localparam logic [RES_W-1:0] JUDGER_WIN     = 2'd2;

  localparam logic [CELL_W-1:0] CELL_EMPTY = 2'b00;
  localparam logic [CELL_W-1:0] CELL_RED   = 2'b10;
  localparam logic [CELL_W-1:0] CELL_GREEN = 2'b01;
endpackage

interface game_turn_ctrl_if;
  import game_turn_pkg::*;

  logic              move_req;
  logic [POS_W-1:0]  move_pos;
  logic              move_ready;
  logic              jdg_en;
  logic              jdg_color;
  logic [POS_W-1:0]  jdg_pos;
  logic              jdg_done;
  logic [RES_W-1:0]  jdg_result;
  logic              ram_wr_en;
  logic [POS_W-1:0]  ram_wr_addr;
  logic [CELL_W-1:0] ram_wr_data;

  modport master (
    input  move_req, move_pos, jdg_done, jdg_result,
    output move_ready, jdg_en, jdg_color, jdg_pos, ram_wr_en, ram_wr_addr, ram_wr_data
  );

  modport slave (
    output move_req, move_pos, jdg_done, jdg_result,
    input  move_ready, jdg_en, jdg_color, jdg_pos, ram_wr_en, ram_wr_addr, ram_wr_data
  );
endinterface

// File: rtl/game_turn_ctrl.sv
// Turn controller for the 8x8 board: clears the board, runs the judger handshake per move,
// commits legal moves to the board RAM, alternates sides and declares win or draw.
module game_turn_ctrl
  import game_turn_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_new_game,
  game_turn_ctrl_if.master   bus,
  output logic               o_cur_side,
  output logic [CNT_W-1:0]   o_move_count,
  output logic               o_move_rejected,
  output logic               o_game_over,
  output logic               o_winner_valid,
  output logic               o_winner
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_WAIT_MOVE,
    S_JUDGE,
    S_COMMIT,
    S_RELEASE,
    S_OVER
  } state_e;

  state_e            r_state;
  logic [POS_W:0]    r_clear_addr;
  logic              r_new_game_pend;
  logic [RES_W-1:0]  r_result;
  logic              r_ended;
  logic              r_move_ready;
  logic              r_jdg_en;
  logic [POS_W-1:0]  r_jdg_pos;
  logic              r_ram_wr_en;
  logic [POS_W-1:0]  r_ram_wr_addr;
  logic [CELL_W-1:0] r_ram_wr_data;
  logic              r_cur_side;
  logic [CNT_W-1:0]  r_move_count;
  logic              r_move_rejected;
  logic              r_game_over;
  logic              r_winner_valid;
  logic              r_winner;

  logic              w_pend_any;
  logic              w_legal;
  logic              w_last_stone;
  logic [CELL_W-1:0] w_cell;

  assign w_pend_any   = r_new_game_pend | i_new_game;
  assign w_legal      = (bus.jdg_result == JUDGER_VALID) || (bus.jdg_result == JUDGER_WIN);
  assign w_last_stone = (r_move_count == CNT_W'(63));
  assign w_cell       = (r_cur_side == SIDE_RED) ? CELL_RED : CELL_GREEN;

  // Clear sweep uses the extra top bit of r_clear_addr as "address 63 already written".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_CLEAR;
      r_clear_addr    <= '0;
      r_new_game_pend <= 1'b0;
      r_result        <= JUDGER_INVALID;
      r_ended         <= 1'b0;
      r_move_ready    <= 1'b0;
      r_jdg_en        <= 1'b0;
      r_jdg_pos       <= '0;
      r_ram_wr_en     <= 1'b0;
      r_ram_wr_addr   <= '0;
      r_ram_wr_data   <= CELL_EMPTY;
      r_cur_side      <= SIDE_RED;
      r_move_count    <= '0;
      r_move_rejected <= 1'b0;
      r_game_over     <= 1'b0;
      r_winner_valid  <= 1'b0;
      r_winner        <= 1'b0;
    end else begin
      r_ram_wr_en     <= 1'b0;
      r_move_rejected <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          r_move_count    <= '0;
          r_cur_side      <= SIDE_RED;
          r_winner_valid  <= 1'b0;
          r_winner        <= 1'b0;
          r_game_over     <= 1'b0;
          r_ended         <= 1'b0;
          r_new_game_pend <= 1'b0;
          if (i_new_game) begin
            r_clear_addr <= '0;
          end else if (r_clear_addr[POS_W]) begin
            r_state      <= S_WAIT_MOVE;
            r_move_ready <= 1'b1;
          end else begin
            r_ram_wr_en   <= 1'b1;
            r_ram_wr_addr <= r_clear_addr[POS_W-1:0];
            r_ram_wr_data <= CELL_EMPTY;
            r_clear_addr  <= r_clear_addr + (POS_W+1)'(1);
          end
        end

        // A restart beats a simultaneous move request.
        S_WAIT_MOVE: begin
          if (i_new_game) begin
            r_state      <= S_CLEAR;
            r_clear_addr <= '0;
            r_move_ready <= 1'b0;
          end else if (bus.move_req) begin
            r_jdg_pos    <= bus.move_pos;
            r_jdg_en     <= 1'b1;
            r_move_ready <= 1'b0;
            r_state      <= S_JUDGE;
          end
        end

        S_JUDGE: begin
          if (i_new_game) r_new_game_pend <= 1'b1;
          if (bus.jdg_done) begin
            r_result <= bus.jdg_result;
            r_jdg_en <= 1'b0;
            if (w_legal) begin
              r_state       <= S_COMMIT;
              r_ram_wr_en   <= 1'b1;
              r_ram_wr_addr <= r_jdg_pos;
              r_ram_wr_data <= w_cell;
            end else begin
              r_move_rejected <= 1'b1;
              r_state         <= S_RELEASE;
            end
          end
        end

        S_COMMIT: begin
          if (i_new_game) r_new_game_pend <= 1'b1;
          r_move_count <= r_move_count + CNT_W'(1);
          if (r_result == JUDGER_WIN) begin
            r_winner       <= r_cur_side;
            r_winner_valid <= 1'b1;
            r_ended        <= 1'b1;
          end else if (w_last_stone) begin
            r_ended <= 1'b1;
          end else begin
            r_cur_side <= ~r_cur_side;
          end
          r_state <= S_RELEASE;
        end

        // Judger must drop done before anything else happens.
        S_RELEASE: begin
          if (i_new_game) r_new_game_pend <= 1'b1;
          if (!bus.jdg_done) begin
            if (w_pend_any) begin
              r_state         <= S_CLEAR;
              r_clear_addr    <= '0;
              r_new_game_pend <= 1'b0;
            end else if (r_ended) begin
              r_state     <= S_OVER;
              r_game_over <= 1'b1;
            end else begin
              r_state      <= S_WAIT_MOVE;
              r_move_ready <= 1'b1;
            end
          end
        end

        S_OVER: begin
          if (i_new_game) begin
            r_state        <= S_CLEAR;
            r_clear_addr   <= '0;
            r_game_over    <= 1'b0;
            r_winner_valid <= 1'b0;
          end
        end

        default: begin
          r_state      <= S_CLEAR;
          r_clear_addr <= '0;
        end
      endcase
    end
  end

  assign bus.move_ready  = r_move_ready;
  assign bus.jdg_en      = r_jdg_en;
  assign bus.jdg_color   = r_cur_side;
  assign bus.jdg_pos     = r_jdg_pos;
  assign bus.ram_wr_en   = r_ram_wr_en;
  assign bus.ram_wr_addr = r_ram_wr_addr;
  assign bus.ram_wr_data = r_ram_wr_data;

  assign o_cur_side      = r_cur_side;
  assign o_move_count    = r_move_count;
  assign o_move_rejected = r_move_rejected;
  assign o_game_over     = r_game_over;
  assign o_winner_valid  = r_winner_valid;
  assign o_winner        = r_winner;

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Directed bench for game_turn_ctrl with a behavioural judger and a shadow of the board RAM.
module tb_game_turn_ctrl;
  import game_turn_pkg::*;

  logic clk;
  logic rst_n;
  logic new_game;
  logic cur_side;
  logic [6:0] move_count;
  logic move_rejected;
  logic game_over;
  logic winner_valid;
  logic winner;

  game_turn_ctrl_if sif ();

  game_turn_ctrl u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_new_game      (new_game),
    .bus             (sif.master),
    .o_cur_side      (cur_side),
    .o_move_count    (move_count),
    .o_move_rejected (move_rejected),
    .o_game_over     (game_over),
    .o_winner_valid  (winner_valid),
    .o_winner        (winner)
  );

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Judger: answers jlat cycles after en, holds done while en, drops done once en falls.
  int         jlat = 0;
  logic [1:0] jres = JUDGER_VALID;
  int         jcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sif.jdg_done   <= 1'b0;
      sif.jdg_result <= JUDGER_INVALID;
      jcnt           <= 0;
    end else if (sif.jdg_en) begin
      if (!sif.jdg_done) begin
        if (jcnt >= jlat) begin
          sif.jdg_done   <= 1'b1;
          sif.jdg_result <= jres;
        end else begin
          jcnt <= jcnt + 1;
        end
      end
    end else begin
      sif.jdg_done <= 1'b0;
      jcnt         <= 0;
    end
  end

  // Board shadow and write bookkeeping.
  logic [1:0] board [64];
  int wr_total = 0;
  int overlap  = 0;
  always @(posedge clk) begin
    if (rst_n && sif.ram_wr_en) begin
      board[sif.ram_wr_addr] <= sif.ram_wr_data;
      wr_total <= wr_total + 1;
      if (sif.jdg_en) overlap <= overlap + 1;
    end
  end

  task automatic check_sweep(input string tag);
    int idx, gaps;
    bit done, last63;
    idx = 0; gaps = 0; done = 0; last63 = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (sif.move_ready) begin done = 1; break; end
      if (sif.ram_wr_en) begin
        checks++;
        if (sif.ram_wr_addr !== 6'(idx) || sif.ram_wr_data !== CELL_EMPTY) begin
          errors++;
          $display("FAIL %s clear_write[%0d]: addr %0d data %b, want addr %0d data 00",
                   tag, idx, sif.ram_wr_addr, sif.ram_wr_data, idx);
        end
        last63 = (sif.ram_wr_addr == 6'd63);
        idx++;
      end else begin
        if (idx > 0) gaps++;
        last63 = 0;
      end
    end
    checks++;
    if (!done || idx != 64 || gaps != 0 || !last63) begin
      errors++;
      $display("FAIL %s clear_sweep: ready=%0b writes=%0d gaps=%0d last63=%0b, want 1/64/0/1",
               tag, done, idx, gaps, last63);
    end
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  task automatic do_move(input logic [5:0] pos, output bit ok);
    ok = 0;
    sif.move_pos = pos;
    sif.move_req = 1'b1;
    @(negedge clk);
    sif.move_req = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (sif.move_ready || game_over) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sif.ram_wr_en !== 1'b0 || sif.move_ready !== 1'b0 || sif.jdg_en !== 1'b0 ||
        cur_side !== SIDE_RED || move_count !== 7'd0 || game_over !== 1'b0 ||
        winner_valid !== 1'b0 || move_rejected !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: wr=%b rdy=%b en=%b side=%b cnt=%0d over=%b wv=%b rej=%b, want all 0",
               sif.ram_wr_en, sif.move_ready, sif.jdg_en, cur_side, move_count, game_over,
               winner_valid, move_rejected);
    end
    rst_n = 1'b1;
    check_sweep("reset");
    checks++;
    if (cur_side !== SIDE_RED || move_count !== 7'd0 || sif.ram_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL post_clear: side=%b cnt=%0d wr=%b, want 0 0 0", cur_side, move_count, sif.ram_wr_en);
    end
  endtask

  task automatic test_valid();
    bit saw_wr, ok;
    int w0;
    w0 = wr_total;
    jres = JUDGER_VALID; jlat = 0;
    sif.move_pos = 6'd27;
    sif.move_req = 1'b1;
    @(negedge clk);
    sif.move_req = 1'b0;
    checks++;
    if (sif.jdg_en !== 1'b1 || sif.jdg_pos !== 6'd27 || sif.jdg_color !== SIDE_RED || sif.move_ready !== 1'b0) begin
      errors++;
      $display("FAIL valid_request: en=%b pos=%0d color=%b rdy=%b, want 1 27 0 0",
               sif.jdg_en, sif.jdg_pos, sif.jdg_color, sif.move_ready);
    end
    saw_wr = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sif.ram_wr_en) begin saw_wr = 1; break; end
    end
    checks++;
    if (!saw_wr || sif.ram_wr_addr !== 6'd27 || sif.ram_wr_data !== CELL_RED || sif.jdg_en !== 1'b0) begin
      errors++;
      $display("FAIL valid_commit: seen=%0b addr=%0d data=%b en=%b, want 1 27 10 0",
               saw_wr, sif.ram_wr_addr, sif.ram_wr_data, sif.jdg_en);
    end
    @(negedge clk);
    checks++;
    if (cur_side !== SIDE_GREEN || move_count !== 7'd1 || sif.ram_wr_en !== 1'b0 || sif.jdg_en !== 1'b0) begin
      errors++;
      $display("FAIL valid_update: side=%b cnt=%0d wr=%b en=%b, want 1 1 0 0",
               cur_side, move_count, sif.ram_wr_en, sif.jdg_en);
    end
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sif.move_ready) begin ok = 1; break; end
    end
    checks++;
    if (!ok || sif.jdg_en !== 1'b0 || (wr_total - w0) != 1 || board[27] !== CELL_RED) begin
      errors++;
      $display("FAIL valid_release: ready=%0b en=%b writes=%0d cell27=%b, want 1 0 1 10",
               ok, sif.jdg_en, wr_total - w0, board[27]);
    end
  endtask

  task automatic test_invalid();
    int rej, wr;
    bit ok;
    rej = 0; wr = 0; ok = 0;
    jres = JUDGER_INVALID; jlat = 0;
    sif.move_pos = 6'd27;
    sif.move_req = 1'b1;
    @(negedge clk);
    sif.move_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (move_rejected) rej++;
      if (sif.ram_wr_en) wr++;
      if (sif.move_ready) begin ok = 1; break; end
    end
    checks++;
    if (!ok || rej != 1 || wr != 0 || cur_side !== SIDE_GREEN || move_count !== 7'd1) begin
      errors++;
      $display("FAIL invalid_move: ready=%0b rej_cycles=%0d writes=%0d side=%b cnt=%0d, want 1 1 0 1 1",
               ok, rej, wr, cur_side, move_count);
    end
  endtask

  task automatic test_win();
    int wr, en_hi;
    bit ok;
    logic [5:0] waddr;
    logic [1:0] wdata;
    wr = 0; en_hi = 0; ok = 0; waddr = '0; wdata = '0;
    jres = JUDGER_WIN; jlat = 2;
    sif.move_pos = 6'd9;
    sif.move_req = 1'b1;
    @(negedge clk);
    sif.move_req = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (sif.ram_wr_en) begin wr++; waddr = sif.ram_wr_addr; wdata = sif.ram_wr_data; end
      if (game_over) begin ok = 1; break; end
    end
    checks++;
    if (wr != 1 || waddr !== 6'd9 || wdata !== CELL_GREEN) begin
      errors++;
      $display("FAIL win_commit: writes=%0d addr=%0d data=%b, want 1 9 01", wr, waddr, wdata);
    end
    checks++;
    if (!ok || winner_valid !== 1'b1 || winner !== SIDE_GREEN || move_count !== 7'd2 || sif.move_ready !== 1'b0) begin
      errors++;
      $display("FAIL win_result: over=%0b wv=%b winner=%b cnt=%0d rdy=%b, want 1 1 1 2 0",
               ok, winner_valid, winner, move_count, sif.move_ready);
    end
    wr = 0;
    jres = JUDGER_VALID; jlat = 0;
    sif.move_pos = 6'd10;
    sif.move_req = 1'b1;
    @(negedge clk);
    sif.move_req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (sif.jdg_en) en_hi++;
      if (sif.ram_wr_en) wr++;
    end
    checks++;
    if (en_hi != 0 || wr != 0 || game_over !== 1'b1 || winner_valid !== 1'b1) begin
      errors++;
      $display("FAIL over_ignores_req: en_cycles=%0d writes=%0d over=%b wv=%b, want 0 0 1 1",
               en_hi, wr, game_over, winner_valid);
    end
  endtask

  task automatic test_new_game_mid_judge();
    int wr, en_hi;
    bit ok;
    logic [5:0] a0, a1, alast;
    logic [1:0] d0;
    pulse_new_game();
    checks++;
    if (game_over !== 1'b0 || winner_valid !== 1'b0) begin
      errors++;
      $display("FAIL new_game_from_over: over=%b wv=%b, want 0 0", game_over, winner_valid);
    end
    check_sweep("after_over");
    wr = 0; en_hi = 0; ok = 0; a0 = '0; a1 = '1; alast = '0; d0 = '0;
    jres = JUDGER_VALID; jlat = 10;
    sif.move_pos = 6'd5;
    sif.move_req = 1'b1;
    @(negedge clk);
    sif.move_req = 1'b0;
    if (sif.jdg_en) en_hi++;
    @(negedge clk);
    if (sif.jdg_en) en_hi++;
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    if (sif.jdg_en) en_hi++;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (sif.jdg_en) en_hi++;
      if (sif.ram_wr_en) begin
        if (wr == 0) begin a0 = sif.ram_wr_addr; d0 = sif.ram_wr_data; end
        if (wr == 1) a1 = sif.ram_wr_addr;
        alast = sif.ram_wr_addr;
        wr++;
      end
      if (sif.move_ready) begin ok = 1; break; end
    end
    checks++;
    if (a0 !== 6'd5 || d0 !== CELL_RED || en_hi < 11) begin
      errors++;
      $display("FAIL pend_commit: first_addr=%0d data=%b en_cycles=%0d, want 5 10 >=11", a0, d0, en_hi);
    end
    checks++;
    if (!ok || wr != 65 || a1 !== 6'd0 || alast !== 6'd63 || move_count !== 7'd0 || cur_side !== SIDE_RED) begin
      errors++;
      $display("FAIL pend_clear: ready=%0b writes=%0d second=%0d last=%0d cnt=%0d side=%b, want 1 65 0 63 0 0",
               ok, wr, a1, alast, move_count, cur_side);
    end
  endtask

  task automatic test_simultaneous();
    int en_hi;
    en_hi = 0;
    sif.move_pos = 6'd3;
    sif.move_req = 1'b1;
    new_game = 1'b1;
    @(negedge clk);
    sif.move_req = 1'b0;
    new_game = 1'b0;
    if (sif.jdg_en) en_hi++;
    checks++;
    if (en_hi != 0 || sif.move_ready !== 1'b0) begin
      errors++;
      $display("FAIL simul_new_game: en=%0d rdy=%b, want 0 0", en_hi, sif.move_ready);
    end
    check_sweep("simul");
  endtask

  task automatic test_new_game_in_clear();
    pulse_new_game();
    repeat (10) @(negedge clk);
    checks++;
    if (sif.ram_wr_en !== 1'b1 || sif.ram_wr_addr === 6'd0) begin
      errors++;
      $display("FAIL mid_sweep_state: wr=%b addr=%0d, want 1 nonzero", sif.ram_wr_en, sif.ram_wr_addr);
    end
    pulse_new_game();
    check_sweep("restart");
  endtask

  task automatic test_reset_mid_sweep();
    pulse_new_game();
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (sif.ram_wr_en !== 1'b0 || sif.move_ready !== 1'b0 || cur_side !== SIDE_RED || sif.jdg_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_sweep: wr=%b rdy=%b side=%b en=%b, want 0 0 0 0",
               sif.ram_wr_en, sif.move_ready, cur_side, sif.jdg_en);
    end
    rst_n = 1'b1;
    check_sweep("reset_mid");
  endtask

  task automatic test_draw();
    int bad_moves, bad_cells;
    bit ok;
    logic [1:0] want;
    bad_moves = 0; bad_cells = 0;
    jres = JUDGER_VALID; jlat = 0;
    for (int i = 0; i < 64; i++) begin
      do_move(6'(i), ok);
      if (!ok) bad_moves++;
      if (i < 63 && (game_over || !sif.move_ready)) bad_moves++;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      want = (i % 2 == 0) ? CELL_RED : CELL_GREEN;
      if (board[i] !== want) bad_cells++;
    end
    checks++;
    if (bad_moves != 0 || bad_cells != 0) begin
      errors++;
      $display("FAIL draw_moves: bad_moves=%0d bad_cells=%0d, want 0 0", bad_moves, bad_cells);
    end
    checks++;
    if (game_over !== 1'b1 || winner_valid !== 1'b0 || move_count !== 7'd64 ||
        cur_side !== SIDE_GREEN || sif.move_ready !== 1'b0) begin
      errors++;
      $display("FAIL draw_result: over=%b wv=%b cnt=%0d side=%b rdy=%b, want 1 0 64 1 0",
               game_over, winner_valid, move_count, cur_side, sif.move_ready);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    new_game     = 1'b0;
    sif.move_req = 1'b0;
    sif.move_pos = '0;
    @(negedge clk);
    test_reset();
    test_valid();
    test_invalid();
    test_win();
    test_new_game_mid_judge();
    test_simultaneous();
    test_new_game_in_clear();
    test_reset_mid_sweep();
    test_draw();
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL write_read_overlap: cycles=%0d, want 0", overlap);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
